// File: rtl/lut_cfg_loader.sv
// ---------------------------------------------------------------------------
// lut_cfg_loader
//
// Configuration sequencer for a column of fracturable dual-LUT slices. It
// collects a word-wide configuration stream, assembles one complete slice
// configuration (two LUT tables plus the fracture bit in the MSB), and then
// commits it to one slice with a single-cycle one-hot enable. Slices are
// loaded in order, starting from slice 0.
//
// Ports
//   cclk        in   configuration clock, all state on the rising edge
//   rst_n       in   asynchronous active-low reset
//   start       in   one-cycle pulse, begins a full load from slice 0
//   din         in   DIN_W-bit configuration stream word
//   din_valid   in   din carries a word
//   din_ready   out  loader accepts din this cycle (LOAD only)
//   config_out  out  assembled slice configuration, CFG_BITS wide
//   cen_out     out  one-hot per-slice configuration enable (COMMIT only)
//   busy        out  load in progress (LOAD or COMMIT)
//   done        out  every slice committed; held until start or reset
// ---------------------------------------------------------------------------
module lut_cfg_loader #(
  parameter int INPUTS     = 4,
  parameter int DIN_W      = 8,
  parameter int NUM_SLICES = 4
) (
  input  logic                      cclk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic [DIN_W-1:0]          din,
  input  logic                      din_valid,
  output logic                      din_ready,
  output logic [2*(2**INPUTS):0]    config_out,
  output logic [NUM_SLICES-1:0]     cen_out,
  output logic                      busy,
  output logic                      done
);

  localparam int CFG_BITS        = 2 * (2 ** INPUTS) + 1;
  localparam int WORDS_PER_SLICE = (CFG_BITS + DIN_W - 1) / DIN_W;
  localparam int ASM_W           = WORDS_PER_SLICE * DIN_W;
  localparam int IDX_W           = (NUM_SLICES > 1) ? $clog2(NUM_SLICES) : 1;
  localparam int WC_W            = (WORDS_PER_SLICE > 1) ? $clog2(WORDS_PER_SLICE) : 1;

  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_SLICES - 1);
  localparam logic [WC_W-1:0]  LAST_WORD = WC_W'(WORDS_PER_SLICE - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOAD   = 2'd1,
    ST_COMMIT = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  state_t                  state_q,      state_d;
  logic [IDX_W-1:0]        slice_idx_q,  slice_idx_d;
  logic [WC_W-1:0]         word_cnt_q,   word_cnt_d;
  logic [ASM_W-1:0]        asm_q,        asm_d;
  logic [CFG_BITS-1:0]     config_out_q, config_out_d;
  logic [NUM_SLICES-1:0]   cen_out_q,    cen_out_d;
  logic                    din_ready_q,  din_ready_d;
  logic                    busy_q,       busy_d;
  logic                    done_q,       done_d;

  // Next-state, datapath and registered-output computation.
  always_comb begin
    state_d      = state_q;
    slice_idx_d  = slice_idx_q;
    word_cnt_d   = word_cnt_q;
    asm_d        = asm_q;
    config_out_d = config_out_q;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d     = ST_LOAD;
          slice_idx_d = '0;
          word_cnt_d  = '0;
          asm_d       = '0;
        end else begin
          state_d = state_q;
        end
      end

      ST_LOAD: begin
        // din_ready_q is high exactly while in LOAD, so this is the
        // handshake as seen by the upstream source.
        if (din_valid && din_ready_q) begin
          for (int w = 0; w < WORDS_PER_SLICE; w++) begin
            if (word_cnt_q == WC_W'(w)) begin
              asm_d[w*DIN_W +: DIN_W] = din;
            end else begin
              asm_d[w*DIN_W +: DIN_W] = asm_q[w*DIN_W +: DIN_W];
            end
          end
          if (word_cnt_q == LAST_WORD) begin
            // Final word: publish the assembled word (padding bits above
            // CFG_BITS are dropped here) and commit on the next cycle.
            state_d      = ST_COMMIT;
            config_out_d = asm_d[CFG_BITS-1:0];
          end else begin
            word_cnt_d = word_cnt_q + WC_W'(1);
          end
        end else begin
          state_d = ST_LOAD;
        end
      end

      ST_COMMIT: begin
        word_cnt_d = '0;
        asm_d      = '0;
        if (slice_idx_q == LAST_IDX) begin
          state_d = ST_DONE;
        end else begin
          slice_idx_d = slice_idx_q + IDX_W'(1);
          state_d     = ST_LOAD;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Outputs are registered from the next state so they line up with it.
    din_ready_d = (state_d == ST_LOAD);
    busy_d      = (state_d == ST_LOAD) || (state_d == ST_COMMIT);
    done_d      = (state_d == ST_DONE);
    for (int s = 0; s < NUM_SLICES; s++) begin
      cen_out_d[s] = (state_d == ST_COMMIT) && (slice_idx_d == IDX_W'(s));
    end
  end

  // State and output registers with asynchronous clear.
  always_ff @(posedge cclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      slice_idx_q  <= '0;
      word_cnt_q   <= '0;
      asm_q        <= '0;
      config_out_q <= '0;
      cen_out_q    <= '0;
      din_ready_q  <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      slice_idx_q  <= slice_idx_d;
      word_cnt_q   <= word_cnt_d;
      asm_q        <= asm_d;
      config_out_q <= config_out_d;
      cen_out_q    <= cen_out_d;
      din_ready_q  <= din_ready_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  assign din_ready  = din_ready_q;
  assign config_out = config_out_q;
  assign cen_out    = cen_out_q;
  assign busy       = busy_q;
  assign done       = done_q;

endmodule

// File: tb/tb_lut_cfg_loader.sv
// ---------------------------------------------------------------------------
// tb_lut_cfg_loader
//
// Self-checking bench for lut_cfg_loader at default parameters (33-bit
// config, 8-bit words, 4 slices). Expected {cen_out, config_out} pairs are
// queued when the last word of a slice is driven and compared by a monitor
// whenever a commit pulse appears.
// ---------------------------------------------------------------------------
module tb_lut_cfg_loader;

  logic        cclk;
  logic        rst_n;
  logic        start;
  logic [7:0]  din;
  logic        din_valid;
  logic        din_ready;
  logic [32:0] config_out;
  logic [3:0]  cen_out;
  logic        busy;
  logic        done;

  int n_checks = 0;
  int n_pass   = 0;

  // {cen_out, config_out} expected at each commit
  logic [36:0] sb[$];

  lut_cfg_loader #(.INPUTS(4), .DIN_W(8), .NUM_SLICES(4)) dut (
    .cclk       (cclk),
    .rst_n      (rst_n),
    .start      (start),
    .din        (din),
    .din_valid  (din_valid),
    .din_ready  (din_ready),
    .config_out (config_out),
    .cen_out    (cen_out),
    .busy       (busy),
    .done       (done)
  );

  initial cclk = 1'b0;
  always #5 cclk = ~cclk;

  // Commit monitor: every cen pulse must match the oldest expectation.
  always @(negedge cclk) begin
    logic [36:0] e;
    if (rst_n === 1'b1 && cen_out !== 4'b0000) begin
      n_checks++;
      if (sb.size() == 0) begin
        $display("FAIL commit_unexpected got cen=%b cfg=%h want no commit", cen_out, config_out);
      end else begin
        e = sb.pop_front();
        if ({cen_out, config_out} !== e)
          $display("FAIL commit got cen=%b cfg=%h want cen=%b cfg=%h",
                   cen_out, config_out, e[36:33], e[32:0]);
        else
          n_pass++;
      end
      n_checks++;
      if (din_ready !== 1'b0 || busy !== 1'b1)
        $display("FAIL commit_flags got ready=%b busy=%b want ready=0 busy=1", din_ready, busy);
      else
        n_pass++;
    end
  end

  // Watchdog so the run always terminates.
  initial begin
    #500000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog");
  end

  task automatic pulse_start();
    start = 1'b1;
    @(posedge cclk); #1;
    start = 1'b0;
  endtask

  // Drive one word after 'gap' idle cycles; returns #1 after the accepting edge.
  task automatic send_word(input logic [7:0] w, input int gap);
    int t;
    din_valid = 1'b0;
    repeat (gap) begin @(posedge cclk); #1; end
    din       = w;
    din_valid = 1'b1;
    t = 0;
    while (din_ready !== 1'b1 && t < 40) begin
      @(posedge cclk); #1;
      t++;
    end
    if (t >= 40) begin
      n_checks++;
      $display("FAIL din_ready_timeout got ready=%b want 1", din_ready);
    end else begin
      @(posedge cclk); #1;
    end
    din_valid = 1'b0;
  endtask

  // Send words [from..to] of a slice; word w is ws[w*8 +: 8]. The expected
  // commit is queued just before the fifth word goes out.
  task automatic send_slice(input logic [39:0] ws, input int idx,
                            input int from, input int to, input int max_gap);
    logic [3:0] cen_exp;
    for (int w = from; w <= to; w++) begin
      if (w == 4) begin
        cen_exp = 4'b0001 << idx;
        sb.push_back({cen_exp, ws[32:0]});
      end
      send_word(ws[w*8 +: 8], (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0);
    end
  endtask

  task automatic check_sb_drained(input string name);
    repeat (2) begin @(posedge cclk); #1; end
    n_checks++;
    if (sb.size() != 0)
      $display("FAIL %s_pending got %0d commits outstanding want 0", name, sb.size());
    else
      n_pass++;
  endtask

  // Checks taken in the cycle after the final commit.
  task automatic check_done_state(input string name);
    @(posedge cclk); #1;
    n_checks++;
    if (done !== 1'b1 || busy !== 1'b0 || din_ready !== 1'b0 || cen_out !== 4'b0000)
      $display("FAIL %s_done got done=%b busy=%b ready=%b cen=%b want 1 0 0 0000",
               name, done, busy, din_ready, cen_out);
    else
      n_pass++;
    repeat (5) begin @(posedge cclk); #1; end
    n_checks++;
    if (done !== 1'b1 || busy !== 1'b0)
      $display("FAIL %s_done_hold got done=%b busy=%b want 1 0", name, done, busy);
    else
      n_pass++;
  endtask

  localparam logic [39:0] S0 = 40'h1F_04_03_02_01;
  localparam logic [39:0] S1 = 40'hA5_3C_77_E1_10;
  localparam logic [39:0] S2 = 40'h00_FF_5A_81_C3;
  localparam logic [39:0] S3 = 40'h6B_12_34_56_9E;

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; din = 8'h00; din_valid = 1'b0;
    #1;
    n_checks++;
    if (config_out !== 33'h0 || cen_out !== 4'b0 || din_ready !== 1'b0 || busy !== 1'b0 || done !== 1'b0)
      $display("FAIL reset_outputs got cfg=%h cen=%b ready=%b busy=%b done=%b want all 0",
               config_out, cen_out, din_ready, busy, done);
    else
      n_pass++;
    repeat (3) @(posedge cclk);
    #1 rst_n = 1'b1;
    // IDLE must not accept data
    din = 8'hAA; din_valid = 1'b1;
    repeat (4) begin @(posedge cclk); #1; end
    n_checks++;
    if (din_ready !== 1'b0 || busy !== 1'b0 || cen_out !== 4'b0 || config_out !== 33'h0)
      $display("FAIL idle_ignores_din got ready=%b busy=%b cen=%b cfg=%h want 0 0 0000 0",
               din_ready, busy, cen_out, config_out);
    else
      n_pass++;
    din_valid = 1'b0;
  endtask

  task automatic test_basic();
    pulse_start();
    n_checks++;
    if (busy !== 1'b1 || din_ready !== 1'b1)
      $display("FAIL start_load got busy=%b ready=%b want 1 1", busy, din_ready);
    else
      n_pass++;
    send_slice(S0, 0, 0, 4, 0);
    // now in the cycle after the edge that took the final word
    n_checks++;
    if (cen_out !== 4'b0001 || config_out !== 33'h1_0403_0201 || din_ready !== 1'b0)
      $display("FAIL basic_commit got cen=%b cfg=%h ready=%b want 0001 104030201 0",
               cen_out, config_out, din_ready);
    else
      n_pass++;
    @(posedge cclk); #1;
    n_checks++;
    if (cen_out !== 4'b0000 || config_out !== 33'h1_0403_0201 || din_ready !== 1'b1)
      $display("FAIL basic_after got cen=%b cfg=%h ready=%b want 0000 104030201 1",
               cen_out, config_out, din_ready);
    else
      n_pass++;
  endtask

  task automatic test_full_column();
    send_slice(S1, 1, 0, 4, 0);
    send_slice(S2, 2, 0, 4, 0);
    send_slice(S3, 3, 0, 4, 0);
    n_checks++;
    if (cen_out !== 4'b1000)
      $display("FAIL last_commit got cen=%b want 1000", cen_out);
    else
      n_pass++;
    check_done_state("full");
    check_sb_drained("full");
  endtask

  task automatic test_backpressure();
    pulse_start();
    n_checks++;
    if (done !== 1'b0 || busy !== 1'b1 || din_ready !== 1'b1)
      $display("FAIL restart got done=%b busy=%b ready=%b want 0 1 1", done, busy, din_ready);
    else
      n_pass++;
    send_slice(S0, 0, 0, 4, 10);
    send_slice(S1, 1, 0, 4, 10);
    send_slice(S2, 2, 0, 4, 10);
    send_slice(S3, 3, 0, 4, 10);
    check_done_state("stall");
    check_sb_drained("stall");
  endtask

  task automatic test_ignored_start_fracture();
    logic [39:0] f2;
    logic [39:0] f3;
    f2 = {8'hFE, S2[31:0]};
    f3 = {8'h01, S3[31:0]};
    pulse_start();
    send_slice(S0, 0, 0, 4, 2);
    send_slice(S1, 1, 0, 1, 0);
    pulse_start();
    n_checks++;
    if (busy !== 1'b1 || din_ready !== 1'b1 || done !== 1'b0)
      $display("FAIL ignored_start got busy=%b ready=%b done=%b want 1 1 0", busy, din_ready, done);
    else
      n_pass++;
    send_slice(S1, 1, 2, 4, 0);
    send_slice(f2, 2, 0, 4, 0);
    n_checks++;
    if (config_out[32] !== 1'b0 || config_out[31:0] !== f2[31:0])
      $display("FAIL fracture_fe got cfg=%h want %h", config_out, {1'b0, f2[31:0]});
    else
      n_pass++;
    send_slice(f3, 3, 0, 4, 0);
    n_checks++;
    if (config_out[32] !== 1'b1 || config_out[31:0] !== f3[31:0])
      $display("FAIL fracture_01 got cfg=%h want %h", config_out, {1'b1, f3[31:0]});
    else
      n_pass++;
    check_done_state("frac");
    check_sb_drained("frac");
  endtask

  task automatic test_async_reset();
    pulse_start();
    send_slice(S0, 0, 0, 4, 0);
    send_slice(S1, 1, 0, 4, 0);
    send_slice(S2, 2, 0, 2, 0);
    #3 rst_n = 1'b0;
    #1;
    n_checks++;
    if (config_out !== 33'h0 || cen_out !== 4'b0 || din_ready !== 1'b0 || busy !== 1'b0 || done !== 1'b0)
      $display("FAIL async_reset got cfg=%h cen=%b ready=%b busy=%b done=%b want all 0",
               config_out, cen_out, din_ready, busy, done);
    else
      n_pass++;
    @(posedge cclk); #1;
    rst_n = 1'b1;
    repeat (3) begin @(posedge cclk); #1; end
    n_checks++;
    if (busy !== 1'b0 || din_ready !== 1'b0 || cen_out !== 4'b0 || done !== 1'b0)
      $display("FAIL post_reset_idle got busy=%b ready=%b cen=%b done=%b want 0 0 0000 0",
               busy, din_ready, cen_out, done);
    else
      n_pass++;
    pulse_start();
    send_slice(S3, 0, 0, 4, 1);
    send_slice(S2, 1, 0, 4, 1);
    send_slice(S1, 2, 0, 4, 1);
    send_slice(S0, 3, 0, 4, 1);
    check_done_state("rst");
    check_sb_drained("rst");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_full_column();
    test_backpressure();
    test_ignored_start_fracture();
    test_async_reset();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
